// File: rtl/mod_seq_pkg.sv
// ============================================================================
//  Module      : mod_seq_pkg
//  Description : Shared types and helpers for the frame sequencer. Holds the
//                sequencer state enumeration and the CRC8 constants and
//                byte-update function (poly 0x07, MSB-first, no reflection).
//                The CRC state is only declared when MOD_SEQ_CRC8_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_GAP      = 3'd4
`ifdef MOD_SEQ_CRC8_EN
        ,
        ST_CRC      = 3'd5
`endif
    } seq_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One byte of CRC8, processed MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_frame_sequencer_if.sv
// ============================================================================
//  Module      : mod_frame_sequencer_if
//  Description : Byte-stream bundle around the frame sequencer.
//                Upstream side : i_data, i_valid_input (to sequencer), o_ready
//                Modulator side: o_mod_data, o_mod_valid (from sequencer),
//                                i_mod_ready
//                Modport slave is the sequencer's view, master the view of
//                the surrounding logic (byte source + modulator).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mod_frame_sequencer_if #(
    parameter int SIZE_INPUT_BIT = 8
);
    logic [SIZE_INPUT_BIT-1:0] i_data;
    logic                      i_valid_input;
    logic                      o_ready;
    logic [SIZE_INPUT_BIT-1:0] o_mod_data;
    logic                      o_mod_valid;
    logic                      i_mod_ready;

    modport slave (
        input  i_data,
        input  i_valid_input,
        input  i_mod_ready,
        output o_ready,
        output o_mod_data,
        output o_mod_valid
    );

    modport master (
        output i_data,
        output i_valid_input,
        output i_mod_ready,
        input  o_ready,
        input  o_mod_data,
        input  o_mod_valid
    );
endinterface

`default_nettype wire

// File: rtl/mod_frame_sequencer.sv
// ============================================================================
//  Module      : mod_frame_sequencer
//  Description : Frame-level controller in front of the modulator. Each frame
//                is PREAMBLE_LEN preamble bytes, one length byte, len payload
//                bytes pulled from upstream, (optional CRC8 byte), then an
//                idle gap of GAP_CYCLES cycles. Output is a single register
//                stage with a valid/ready handshake.
//  Ports       : i_clk, i_reset (sync, active-high)
//                i_start, i_len  - frame request, sampled in IDLE only
//                o_busy          - state is not IDLE
//                o_frame_done    - one-cycle pulse on the GAP->IDLE step
//                o_err_len       - one-cycle pulse on a start with len==0
//                bus (slave)     - upstream byte stream + modulator byte port
//  Config      : define MOD_SEQ_CRC8_EN to append a CRC8 byte computed over
//                the header and payload bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_frame_sequencer
    import mod_seq_pkg::*;
#(
    parameter int                        SIZE_INPUT_BIT = 8,
    parameter int                        PREAMBLE_LEN   = 4,
    parameter logic [SIZE_INPUT_BIT-1:0] PREAMBLE_BYTE  = 8'h55,
    parameter int                        GAP_CYCLES     = 16
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset,
    input  wire logic              i_start,
    input  wire logic [7:0]        i_len,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_err_len,
    mod_frame_sequencer_if.slave   bus
);

    localparam int c_pre_w = $clog2(PREAMBLE_LEN + 1);
    localparam int c_gap_w = $clog2(GAP_CYCLES + 1);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PREAMBLE_LEN - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

    seq_state_t                r_state_q,     w_state_d;
    logic [7:0]                r_len_q,       w_len_d;
    logic [c_pre_w-1:0]        r_pre_cnt_q,   w_pre_cnt_d;
    logic [7:0]                r_pay_cnt_q,   w_pay_cnt_d;
    logic [c_gap_w-1:0]        r_gap_cnt_q,   w_gap_cnt_d;
    logic [SIZE_INPUT_BIT-1:0] r_mod_data_q,  w_mod_data_d;
    logic                      r_mod_valid_q, w_mod_valid_d;
`ifdef MOD_SEQ_CRC8_EN
    logic [7:0]                r_crc_q,       w_crc_d;
`endif

    logic w_can_load;
    logic w_ready;
    logic w_frame_done;
    logic w_err_len;

    // The output register can take a new byte when empty or being drained.
    assign w_can_load = !r_mod_valid_q || bus.i_mod_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_len_d       = r_len_q;
        w_pre_cnt_d   = r_pre_cnt_q;
        w_pay_cnt_d   = r_pay_cnt_q;
        w_gap_cnt_d   = r_gap_cnt_q;
        w_mod_data_d  = r_mod_data_q;
        // A held byte disappears once the modulator takes it; any load below
        // overrides this, otherwise the register bubbles.
        w_mod_valid_d = r_mod_valid_q && !bus.i_mod_ready;
`ifdef MOD_SEQ_CRC8_EN
        w_crc_d       = r_crc_q;
`endif
        w_ready       = 1'b0;
        w_frame_done  = 1'b0;
        w_err_len     = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len != 8'd0) begin
                        w_len_d     = i_len;
                        w_pre_cnt_d = '0;
                        w_pay_cnt_d = '0;
                        w_gap_cnt_d = '0;
`ifdef MOD_SEQ_CRC8_EN
                        w_crc_d     = CRC8_INIT;
`endif
                        w_state_d   = ST_PREAMBLE;
                    end else begin
                        w_err_len = 1'b1;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (w_can_load) begin
                    w_mod_data_d  = PREAMBLE_BYTE;
                    w_mod_valid_d = 1'b1;
                    w_pre_cnt_d   = r_pre_cnt_q + c_pre_w'(1);
                    if (r_pre_cnt_q == c_pre_last) begin
                        w_state_d = ST_HEADER;
                    end
                end
            end

            ST_HEADER: begin
                if (w_can_load) begin
                    w_mod_data_d  = SIZE_INPUT_BIT'(r_len_q);
                    w_mod_valid_d = 1'b1;
`ifdef MOD_SEQ_CRC8_EN
                    w_crc_d       = crc8_byte(r_crc_q, r_len_q);
`endif
                    w_state_d     = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                // Upstream is only offered a slot when the output register
                // can accept the byte in the same cycle.
                w_ready = w_can_load;
                if (w_can_load && bus.i_valid_input) begin
                    w_mod_data_d  = bus.i_data;
                    w_mod_valid_d = 1'b1;
                    w_pay_cnt_d   = r_pay_cnt_q + 8'd1;
`ifdef MOD_SEQ_CRC8_EN
                    w_crc_d       = crc8_byte(r_crc_q, 8'(bus.i_data));
`endif
                    if (r_pay_cnt_q == (r_len_q - 8'd1)) begin
`ifdef MOD_SEQ_CRC8_EN
                        w_state_d = ST_CRC;
`else
                        w_state_d = ST_GAP;
`endif
                    end
                end
            end

`ifdef MOD_SEQ_CRC8_EN
            ST_CRC: begin
                if (w_can_load) begin
                    w_mod_data_d  = SIZE_INPUT_BIT'(r_crc_q);
                    w_mod_valid_d = 1'b1;
                    w_state_d     = ST_GAP;
                end
            end
`endif

            ST_GAP: begin
                // Gap cycles only count once the last byte has left.
                if (!r_mod_valid_q) begin
                    if (r_gap_cnt_q == c_gap_last) begin
                        w_gap_cnt_d  = '0;
                        w_frame_done = 1'b1;
                        w_state_d    = ST_IDLE;
                    end else begin
                        w_gap_cnt_d = r_gap_cnt_q + c_gap_w'(1);
                    end
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q     <= ST_IDLE;
            r_len_q       <= '0;
            r_pre_cnt_q   <= '0;
            r_pay_cnt_q   <= '0;
            r_gap_cnt_q   <= '0;
            r_mod_data_q  <= '0;
            r_mod_valid_q <= 1'b0;
`ifdef MOD_SEQ_CRC8_EN
            r_crc_q       <= CRC8_INIT;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_len_q       <= w_len_d;
            r_pre_cnt_q   <= w_pre_cnt_d;
            r_pay_cnt_q   <= w_pay_cnt_d;
            r_gap_cnt_q   <= w_gap_cnt_d;
            r_mod_data_q  <= w_mod_data_d;
            r_mod_valid_q <= w_mod_valid_d;
`ifdef MOD_SEQ_CRC8_EN
            r_crc_q       <= w_crc_d;
`endif
        end
    end

    // Combinational pulses are masked during reset so an aborted frame can
    // never report completion and reset-time outputs read as zero.
    assign o_busy          = (r_state_q != ST_IDLE);
    assign o_frame_done    = w_frame_done && !i_reset;
    assign o_err_len       = w_err_len && !i_reset;
    assign bus.o_ready     = w_ready && !i_reset;
    assign bus.o_mod_data  = r_mod_data_q;
    assign bus.o_mod_valid = r_mod_valid_q;

endmodule

`default_nettype wire
